// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared types, requester indices and arbitration helpers for
//               the register-file writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

  localparam logic [1:0] REQ_ALU    = 2'd0;
  localparam logic [1:0] REQ_LD     = 2'd1;
  localparam logic [1:0] REQ_IN     = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'd3;

  // Isolates the lowest set bit, giving a one-hot (or zero) vector.
  function automatic logic [2:0] lowest_one(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

  // First requester found when searching ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] gnt;
    logic [2:0] sum;
    logic [1:0] idx;
    gnt = '0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, ptr} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (gnt == 3'b000 && req[idx]) gnt[idx] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_rr_arb3.sv
// ============================================================================
// Module      : core_rr_arb3
// Description : 3-way one-hot arbiter: round-robin pointer or fixed priority
//               with per-requester starvation counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_rr_arb3
  import core_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 15,
  parameter int WAIT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hold_i,
  input  logic [2:0] valid_i,
  output logic [2:0] grant_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [2:0] starve;

  for (genvar i = 0; i < 3; i++) begin : g_wait
    logic [WAIT_W-1:0] wait_q, wait_d;

    always_comb begin
      wait_d = wait_q;
      if (!valid_i[i] || grant_o[i]) begin
        wait_d = '0;
      end else if (!hold_i && wait_q != '1) begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) wait_q <= '0;
      else       wait_q <= wait_d;
    end

    assign starve[i] = valid_i[i] && (wait_q >= WAIT_W'(MAX_WAIT));
  end

  always_comb begin
    grant_o = '0;
    if (!rst_i && !hold_i) begin
      if (PRIO_MODE == 0)   grant_o = rr_pick(valid_i, ptr_q);
      else if (|starve)     grant_o = lowest_one(starve);
      else                  grant_o = lowest_one(valid_i);
    end
  end

  // Pointer moves to the requester just after the one served.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_o[0])      ptr_d = 2'd1;
    else if (grant_o[1]) ptr_d = 2'd2;
    else if (grant_o[2]) ptr_d = 2'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/core_reg_wb_arb.sv
// ============================================================================
// Module      : core_reg_wb_arb
// Description : Register-file write/byte-input port arbiter with registered
//               strobes. Optional bypass ports under CORE_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_reg_wb_arb
  import core_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 15,
  parameter int WAIT_W    = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HOLD,
  input  logic        ALU_VALID,
  input  reg_addr_t   ALU_ADDR,
  input  xlen_t       ALU_DATA,
  output logic        ALU_READY,
  input  logic        LD_VALID,
  input  reg_addr_t   LD_ADDR,
  input  xlen_t       LD_DATA,
  output logic        LD_READY,
  input  logic        IN_VALID,
  input  reg_addr_t   IN_ADDR,
  input  logic [7:0]  IN_BYTE,
  output logic        IN_READY,
  output logic        WE,
  output reg_addr_t   WADDR,
  output xlen_t       WDATA,
  output logic        INE,
  output logic [7:0]  INDATA,
`ifdef CORE_WB_BYPASS_EN
  input  reg_addr_t   RS1ADDR,
  input  reg_addr_t   RS2ADDR,
  output logic        BYP1_HIT,
  output logic        BYP2_HIT,
  output xlen_t       BYP_DATA,
`endif
  output logic [1:0]  GRANT_ID
);

  logic [2:0] grant;
  logic       we_q, we_d, ine_q, ine_d;
  reg_addr_t  waddr_q, waddr_d;
  xlen_t      wdata_q, wdata_d;
  logic [7:0] indata_q, indata_d;
  logic [1:0] gid_q, gid_d;

  core_rr_arb3 #(
    .PRIO_MODE (PRIO_MODE),
    .MAX_WAIT  (MAX_WAIT),
    .WAIT_W    (WAIT_W)
  ) u_arb (
    .clk_i   (CLK),
    .rst_i   (RST),
    .hold_i  (HOLD),
    .valid_i ({IN_VALID, LD_VALID, ALU_VALID}),
    .grant_o (grant)
  );

  assign ALU_READY = grant[0];
  assign LD_READY  = grant[1];
  assign IN_READY  = grant[2];

  // Writes to x0 are accepted but never strobe the register file.
  always_comb begin
    we_d     = 1'b0;
    ine_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    indata_d = indata_q;
    gid_d    = gid_q;
    if (grant[0]) begin
      waddr_d = ALU_ADDR;
      wdata_d = ALU_DATA;
      we_d    = (ALU_ADDR != '0);
      gid_d   = REQ_ALU;
    end else if (grant[1]) begin
      waddr_d = LD_ADDR;
      wdata_d = LD_DATA;
      we_d    = (LD_ADDR != '0);
      gid_d   = REQ_LD;
    end else if (grant[2]) begin
      waddr_d  = IN_ADDR;
      indata_d = IN_BYTE;
      ine_d    = (IN_ADDR != '0);
      gid_d    = REQ_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      we_q     <= 1'b0;
      ine_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      indata_q <= '0;
      gid_q    <= GRANT_NONE;
    end else begin
      we_q     <= we_d;
      ine_q    <= ine_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      indata_q <= indata_d;
      gid_q    <= gid_d;
    end
  end

  assign WE       = we_q;
  assign INE      = ine_q;
  assign WADDR    = waddr_q;
  assign WDATA    = wdata_q;
  assign INDATA   = indata_q;
  assign GRANT_ID = gid_q;

`ifdef CORE_WB_BYPASS_EN
  assign BYP1_HIT = we_q && (RS1ADDR != '0) && (waddr_q == RS1ADDR);
  assign BYP2_HIT = we_q && (RS2ADDR != '0) && (waddr_q == RS2ADDR);
  assign BYP_DATA = wdata_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_reg_wb_arb.sv
// ============================================================================
// Module      : tb_core_reg_wb_arb
// Description : Directed bench: one round-robin and one fixed-priority DUT
//               (MAX_WAIT=3) driven by shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_reg_wb_arb;

  logic        CLK, RST, HOLD;
  logic        ALU_VALID, LD_VALID, IN_VALID;
  logic [4:0]  ALU_ADDR, LD_ADDR, IN_ADDR;
  logic [31:0] ALU_DATA, LD_DATA;
  logic [7:0]  IN_BYTE;

  logic        rr_alu_rdy, rr_ld_rdy, rr_in_rdy, rr_we, rr_ine;
  logic [4:0]  rr_waddr;
  logic [31:0] rr_wdata;
  logic [7:0]  rr_indata;
  logic [1:0]  rr_gid;

  logic        fp_alu_rdy, fp_ld_rdy, fp_in_rdy, fp_we, fp_ine;
  logic [4:0]  fp_waddr;
  logic [31:0] fp_wdata;
  logic [7:0]  fp_indata;
  logic [1:0]  fp_gid;

`ifdef CORE_WB_BYPASS_EN
  logic [4:0]  RS1ADDR, RS2ADDR;
  logic        rr_byp1, rr_byp2, fp_byp1, fp_byp2;
  logic [31:0] rr_bypd, fp_bypd;
`endif

  int n_checks = 0;
  int n_errors = 0;

  core_reg_wb_arb #(.PRIO_MODE(0), .MAX_WAIT(15), .WAIT_W(8)) u_rr (
    .CLK(CLK), .RST(RST), .HOLD(HOLD),
    .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(rr_alu_rdy),
    .LD_VALID(LD_VALID), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_READY(rr_ld_rdy),
    .IN_VALID(IN_VALID), .IN_ADDR(IN_ADDR), .IN_BYTE(IN_BYTE), .IN_READY(rr_in_rdy),
    .WE(rr_we), .WADDR(rr_waddr), .WDATA(rr_wdata), .INE(rr_ine), .INDATA(rr_indata),
`ifdef CORE_WB_BYPASS_EN
    .RS1ADDR(RS1ADDR), .RS2ADDR(RS2ADDR), .BYP1_HIT(rr_byp1), .BYP2_HIT(rr_byp2), .BYP_DATA(rr_bypd),
`endif
    .GRANT_ID(rr_gid)
  );

  core_reg_wb_arb #(.PRIO_MODE(1), .MAX_WAIT(3), .WAIT_W(8)) u_fp (
    .CLK(CLK), .RST(RST), .HOLD(HOLD),
    .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(fp_alu_rdy),
    .LD_VALID(LD_VALID), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_READY(fp_ld_rdy),
    .IN_VALID(IN_VALID), .IN_ADDR(IN_ADDR), .IN_BYTE(IN_BYTE), .IN_READY(fp_in_rdy),
    .WE(fp_we), .WADDR(fp_waddr), .WDATA(fp_wdata), .INE(fp_ine), .INDATA(fp_indata),
`ifdef CORE_WB_BYPASS_EN
    .RS1ADDR(RS1ADDR), .RS2ADDR(RS2ADDR), .BYP1_HIT(fp_byp1), .BYP2_HIT(fp_byp2), .BYP_DATA(fp_bypd),
`endif
    .GRANT_ID(fp_gid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ALU_VALID = 1'b0;
    LD_VALID  = 1'b0;
    IN_VALID  = 1'b0;
  endtask

  logic [2:0] exp_rdy;
  logic [2:0] fp_seq [5];

  initial begin
    RST = 1'b1; HOLD = 1'b0;
    idle_inputs();
    ALU_ADDR = '0; ALU_DATA = '0; LD_ADDR = '0; LD_DATA = '0; IN_ADDR = '0; IN_BYTE = '0;
`ifdef CORE_WB_BYPASS_EN
    RS1ADDR = '0; RS2ADDR = '0;
`endif
    tick();
    #2 check("rst_ready", {29'd0, rr_in_rdy, rr_ld_rdy, rr_alu_rdy}, 32'd0);
    tick();
    RST = 1'b0;
    check("rst_we",     {31'd0, rr_we},  32'd0);
    check("rst_ine",    {31'd0, rr_ine}, 32'd0);
    check("rst_waddr",  {27'd0, rr_waddr}, 32'd0);
    check("rst_wdata",  rr_wdata, 32'd0);
    check("rst_indata", {24'd0, rr_indata}, 32'd0);
    check("rst_gid_rr", {30'd0, rr_gid}, 32'd3);
    check("rst_gid_fp", {30'd0, fp_gid}, 32'd3);

    // Round-robin with all requesters continuously valid.
    ALU_ADDR = 5'd1; ALU_DATA = 32'h1111_1111;
    LD_ADDR  = 5'd2; LD_DATA  = 32'h2222_2222;
    IN_ADDR  = 5'd3; IN_BYTE  = 8'hA5;
    ALU_VALID = 1'b1; LD_VALID = 1'b1; IN_VALID = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exp_rdy = 3'b001 << (c % 3);
      #2 check("rr_ready", {29'd0, rr_in_rdy, rr_ld_rdy, rr_alu_rdy}, {29'd0, exp_rdy});
      tick();
      check("rr_gid", {30'd0, rr_gid}, 32'(c % 3));
      check("rr_we",  {31'd0, rr_we},  (c % 3 != 2) ? 32'd1 : 32'd0);
      check("rr_ine", {31'd0, rr_ine}, (c % 3 == 2) ? 32'd1 : 32'd0);
      if (c % 3 == 2) check("rr_indata", {24'd0, rr_indata}, 32'hA5);
      else            check("rr_wdata", rr_wdata, (c % 3 == 0) ? 32'h1111_1111 : 32'h2222_2222);
    end
    idle_inputs();
    tick();
    check("idle_we",     {31'd0, rr_we},  32'd0);
    check("idle_ine",    {31'd0, rr_ine}, 32'd0);
    check("hold_waddr",  {27'd0, rr_waddr}, 32'd3);
    check("hold_wdata",  rr_wdata, 32'h2222_2222);
    check("hold_indata", {24'd0, rr_indata}, 32'hA5);

    // Single ALU request; rr pointer is back at 0.
    ALU_ADDR = 5'd5; ALU_DATA = 32'hDEAD_BEEF; ALU_VALID = 1'b1;
    #2 check("alu_ready", {29'd0, rr_in_rdy, rr_ld_rdy, rr_alu_rdy}, 32'b001);
    tick();
    idle_inputs();
    check("alu_we",    {31'd0, rr_we},  32'd1);
    check("alu_waddr", {27'd0, rr_waddr}, 32'd5);
    check("alu_wdata", rr_wdata, 32'hDEAD_BEEF);
    check("alu_ine",   {31'd0, rr_ine}, 32'd0);
    check("alu_gid",   {30'd0, rr_gid}, 32'd0);
`ifdef CORE_WB_BYPASS_EN
    RS1ADDR = 5'd5; RS2ADDR = 5'd6;
    #1 check("byp1_hit",  {31'd0, rr_byp1}, 32'd1);
    check("byp2_hit",  {31'd0, rr_byp2}, 32'd0);
    check("byp_data",  rr_bypd, 32'hDEAD_BEEF);
`endif
    tick();
    check("alu_we_off", {31'd0, rr_we}, 32'd0);

    // Load to x0: accepted, no strobe; rr pointer is 1.
    LD_ADDR = 5'd0; LD_DATA = 32'h1234_5678; LD_VALID = 1'b1;
`ifdef CORE_WB_BYPASS_EN
    RS1ADDR = 5'd0;
`endif
    #2 check("x0_ready", {29'd0, rr_in_rdy, rr_ld_rdy, rr_alu_rdy}, 32'b010);
    tick();
    idle_inputs();
    check("x0_we",  {31'd0, rr_we}, 32'd0);
    check("x0_gid", {30'd0, rr_gid}, 32'd1);
`ifdef CORE_WB_BYPASS_EN
    check("x0_byp1", {31'd0, rr_byp1}, 32'd0);
`endif

    // HOLD two cycles; rr pointer is 2 and must survive.
    LD_ADDR = 5'd2; IN_ADDR = 5'd4; IN_BYTE = 8'h5A;
    HOLD = 1'b1; ALU_VALID = 1'b1; LD_VALID = 1'b1; IN_VALID = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2 check("hold_ready", {29'd0, rr_in_rdy, rr_ld_rdy, rr_alu_rdy}, 32'd0);
      tick();
      check("hold_we", {31'd0, rr_we | rr_ine}, 32'd0);
    end
    HOLD = 1'b0;
    #2 check("post_hold_ready", {29'd0, rr_in_rdy, rr_ld_rdy, rr_alu_rdy}, 32'b100);
    tick();
    idle_inputs();
    check("post_hold_ine",    {31'd0, rr_ine}, 32'd1);
    check("post_hold_indata", {24'd0, rr_indata}, 32'h5A);
    tick();

    // Fixed priority, MAX_WAIT=3: IN starts one cycle before LD.
    fp_seq[0] = 3'b001; fp_seq[1] = 3'b001; fp_seq[2] = 3'b001;
    fp_seq[3] = 3'b100; fp_seq[4] = 3'b010;
    IN_ADDR = 5'd3; IN_BYTE = 8'h3C; ALU_ADDR = 5'd1; LD_ADDR = 5'd2;
    ALU_VALID = 1'b1; IN_VALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) LD_VALID = 1'b1;
      #2 check("fp_ready", {29'd0, fp_in_rdy, fp_ld_rdy, fp_alu_rdy}, {29'd0, fp_seq[c]});
      tick();
      if (c == 3) begin
        IN_VALID = 1'b0;
        check("fp_in_ine", {31'd0, fp_ine}, 32'd1);
        check("fp_in_gid", {30'd0, fp_gid}, 32'd2);
      end
    end
    check("fp_ld_gid", {30'd0, fp_gid}, 32'd1);
    idle_inputs();
    tick();

    // Reset the cycle after an ALU grant cancels nothing already out but clears state.
    ALU_ADDR = 5'd7; ALU_DATA = 32'hCAFE_F00D; ALU_VALID = 1'b1;
    #2 check("pre_rst_ready", {31'd0, rr_alu_rdy}, 32'd1);
    tick();
    RST = 1'b1;
    check("pre_rst_we", {31'd0, rr_we}, 32'd1);
    #2 check("rst_gated_ready", {31'd0, rr_alu_rdy}, 32'd0);
    tick();
    RST = 1'b0;
    idle_inputs();
    check("mid_rst_we",    {31'd0, rr_we}, 32'd0);
    check("mid_rst_gid",   {30'd0, rr_gid}, 32'd3);
    check("mid_rst_waddr", {27'd0, rr_waddr}, 32'd0);
    check("mid_rst_wdata", rr_wdata, 32'd0);
    check("mid_rst_indat", {24'd0, rr_indata}, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_reg_wb_arb.md
Name: core_reg_wb_arb

Overview:
- Write-port arbiter for the integer register file.
- Shares the register file's single write port (WE/WADDR/WDATA) and its byte-input port (INE/INDATA) among three requesters: ALU writeback (req 0), load writeback (req 1) and input-byte unit (req 2).
- Uses a valid/ready handshake per requester. Arbitration is round-robin or fixed-priority with an anti-starvation counter.
- Outputs are registered and drive the register file directly.

Parameters:
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (req0 > req1 > req2) with starvation guard.
- MAX_WAIT, 15, cycles a valid requester may be refused in PRIO_MODE=1 before it is force-granted; range 1..255.
- WAIT_W, 8, width of each wait counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- HOLD  in  1  when 1, no grant is issued (used by the core controller during redirect/trap).
- ALU_VALID  in  1  ALU writeback request.
- ALU_ADDR  in  5  ALU destination register.
- ALU_DATA  in  32  ALU result.
- ALU_READY  out  1  ALU request accepted this cycle.
- LD_VALID  in  1  load writeback request.
- LD_ADDR  in  5  load destination register.
- LD_DATA  in  32  load data.
- LD_READY  out  1  load request accepted this cycle.
- IN_VALID  in  1  input-byte request.
- IN_ADDR  in  5  destination register for the byte.
- IN_BYTE  in  8  input byte.
- IN_READY  out  1  input-byte request accepted this cycle.
- WE  out  1  register-file write enable.
- WADDR  out  5  register-file write address; shared by WE and INE.
- WDATA  out  32  register-file write data.
- INE  out  1  register-file byte-input enable.
- INDATA  out  8  register-file byte-input data.
- GRANT_ID  out  2  index of the last accepted requester; 3 = none.

Behaviour:
- Handshake: a transfer occurs on requester i when VALID_i & READY_i.
  - READY is combinational from the current VALIDs, HOLD and the arbiter state.
  - READY is at most one-hot. READY_i never depends on VALID_i being low.
  - A requester must hold VALID, ADDR and DATA stable until its READY is seen.
- No grant is issued when HOLD=1 or RST=1. All READY signals are 0 in those cycles.
- Round-robin (PRIO_MODE=0):
  - The pointer PTR (0..2) names the highest-priority requester. Search order is PTR, PTR+1, PTR+2, mod 3.
  - After a grant to k, PTR <= (k+1) mod 3.
  - With no grant, PTR holds. Reset value of PTR is 0.
- Fixed priority (PRIO_MODE=1):
  - Each requester has a wait counter WAIT_i that increments, saturating, when VALID_i=1 and READY_i=0. It clears on grant or when VALID_i=0.
  - If any WAIT_i >= MAX_WAIT, the lowest-index such requester is granted, overriding normal priority.
  - HOLD cycles do not increment the counters.
- Output stage, with latency of 1 cycle from handshake to register-file strobe:
  - Grant to req 0 or req 1: next cycle WE=1, WADDR=addr, WDATA=data, INE=0.
  - Grant to req 2: next cycle INE=1, WADDR=IN_ADDR, INDATA=IN_BYTE, WE=0.
  - No grant: WE=0 and INE=0. WADDR, WDATA and INDATA hold their last values.
- Address x0:
  - The request is accepted (READY=1) but WE and INE stay 0 next cycle.
  - GRANT_ID still reports the requester.
- Simultaneous requests to the same register: the order of writes follows grant order. The arbiter does not merge writes.
- Reset values: WE=0, INE=0, WADDR=0, WDATA=0, INDATA=0, GRANT_ID=3, PTR=0, all WAIT_i=0.
- Reset mid-operation: a strobe scheduled for the cycle after reset is cancelled. An in-flight transfer is lost, and requesters re-present after reset.

Optional Feature:
- Macro: CORE_WB_BYPASS_EN.
- When defined, adds the following ports:
  - RS1ADDR in 5 and RS2ADDR in 5.
  - BYP1_HIT out 1, BYP2_HIT out 1 and BYP_DATA out 32.
- Bypass rules:
  - BYPn_HIT=1 combinationally when WE=1 and WADDR==RSnADDR!=0.
  - BYP_DATA=WDATA.
  - INE strobes never produce a hit.
- When not defined, these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg holds:
  - Typedef reg_addr_t (5 bits) and typedef xlen_t (32 bits).
  - Constants REQ_ALU=0, REQ_LD=1, REQ_IN=2, GRANT_NONE=3.
- One sub-module, core_rr_arb3: a 3-way arbiter containing PTR, the wait counters and the one-hot grant logic.
- core_reg_wb_arb instantiates core_rr_arb3 and adds the muxing and the output register.

Test Plan:
- Single ALU request (ALU_ADDR=5, ALU_DATA=0xDEADBEEF) -> ALU_READY=1 in the same cycle; next cycle WE=1, WADDR=5, WDATA=0xDEADBEEF, INE=0; GRANT_ID=0.
- All three VALID held for 6 cycles, PRIO_MODE=0 -> grant sequence 0,1,2,0,1,2; one WE/INE strobe per cycle; the INE strobes carry IN_BYTE.
- PRIO_MODE=1, MAX_WAIT=3, ALU_VALID and LD_VALID held continuously, IN_VALID=1 -> req 2 is refused 3 cycles and is granted in the 4th cycle.
- LD request to x0 -> LD_READY=1; next cycle WE=0 and GRANT_ID=1. With CORE_WB_BYPASS_EN, RS1ADDR=0 gives BYP1_HIT=0.
- HOLD=1 for 2 cycles with all VALID=1 -> all READY=0 and WE=0; PTR is unchanged and the first grant after HOLD drops matches the pre-HOLD pointer.
- RST pulsed the cycle after an ALU grant -> WE=0 in the following cycle; all outputs return to reset values and GRANT_ID=3.
